// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: packs big-endian bytes into 32-bit words,
// writes them into instruction memory, then releases the core from reset.
module imem_boot_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_W = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [23:0]       r_shift;
    logic [1:0]        r_bcnt;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W:0]   r_count;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;

    logic              w_xfer;
    logic [ADDR_W:0]   w_count;
    logic [ADDR_W:0]   w_wcnt_nxt;

    assign byte_ready = (r_state == S_LOAD);
    assign imem_we    = (r_state == S_WRITE);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;

    assign w_xfer     = byte_valid & byte_ready;
    assign w_wcnt_nxt = r_wcnt + ONE_W;

    // Zero or oversize requests load the whole memory
    assign w_count = ((word_count == '0) || (word_count > DEPTH)) ?
                     DEPTH : word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_shift   <= '0;
            r_bcnt    <= '0;
            r_wcnt    <= '0;
            r_count   <= '0;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The done cycle is IDLE too, but a start there is dropped
                    if (start && !r_done) begin
                        r_count   <= w_count;
                        r_addr    <= '0;
                        r_bcnt    <= '0;
                        r_wcnt    <= '0;
                        r_busy    <= 1'b1;
                        r_cpu_rst <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        if (r_bcnt == 2'd3) begin
                            r_wdata <= {r_shift, byte_data};
                            r_bcnt  <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_shift <= {r_shift[15:0], byte_data};
                            r_bcnt  <= r_bcnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_wcnt <= w_wcnt_nxt;
                    // Final word keeps its address so a full load never wraps
                    if (w_wcnt_nxt == r_count) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_addr  <= r_addr + ONE_A;
                        r_state <= S_LOAD;
                    end
                end
                S_RELEASE: begin
                    r_busy    <= 1'b0;
                    r_cpu_rst <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
